step_controller: RTL and testbench

Upstream run/step controller for the pipelined processor core. It debounces the board push-buttons and generates a registered one-cycle-granular `step_en` that gates every pipeline stage (fetch, operand fetch, execute, memory, write-back). This replaces manual clocking from a key with a clean enable in the `CLOCK_50` domain. It supports free-run, single-step and halt-on-request, and keeps an executed-cycle counter for the display path.

---
 rtl/step_controller.sv | 163 ++++++++++++++++
 tb/tb_step_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// Run/single-step/burst controller: debounced push-buttons drive a registered pipeline enable.
// Optional burst key and BURST state are enabled by defining STEP_CTRL_BURST_EN.
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 24,
  parameter int BURST_LEN       = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             KEY_STEP,
  input  logic             KEY_RUN,
  input  logic             KEY_BURST,
  input  logic             halt_in,
  output logic             step_en,
  output logic             running,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam int K_RUN  = 0;
  localparam int K_STEP = 1;

`ifdef STEP_CTRL_BURST_EN
  localparam int NK      = 3;
  localparam int K_BURST = 2;
  logic [NK-1:0] key_raw;
  assign key_raw = {KEY_BURST, KEY_STEP, KEY_RUN};
`else
  localparam int NK = 2;
  logic [NK-1:0] key_raw;
  logic          unused_key_burst;
  assign key_raw          = {KEY_STEP, KEY_RUN};
  assign unused_key_burst = KEY_BURST;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  logic [1:0]    vld_q;
  logic [NK-1:0] sync1_q, sync2_q, lvl_q, armed_q, press_q;
  logic [DW-1:0] db_cnt_q [NK];

  // A key stays disarmed after reset until it has been seen released for a full
  // debounce window, so a button held through reset never produces a press.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      vld_q   <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
      lvl_q   <= '1;
      armed_q <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < NK; i++) db_cnt_q[i] <= '0;
    end else begin
      vld_q   <= {vld_q[0], 1'b1};
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int unsigned i = 0; i < NK; i++) begin
        if (!armed_q[i]) begin
          if (vld_q[1] && sync2_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
              armed_q[i]  <= 1'b1;
              db_cnt_q[i] <= '0;
            end else begin
              db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
          end else begin
            db_cnt_q[i] <= '0;
          end
        end else if (sync2_q[i] != lvl_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            lvl_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
            press_q[i]  <= ~sync2_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic ev_run, ev_step, ev_burst;
  assign ev_run  = press_q[K_RUN];
  assign ev_step = press_q[K_STEP];
`ifdef STEP_CTRL_BURST_EN
  assign ev_burst = press_q[K_BURST];
`else
  assign ev_burst = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic [7:0]       burst_q, burst_d;
  logic [CNT_W-1:0] cyc_q;

  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    burst_d = burst_q;
    if (halt_in) begin
      state_d = S_IDLE;
      burst_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev_run) begin
            state_d = S_RUN;
            step_d  = 1'b1;
          end else if (ev_burst) begin
            state_d = S_BURST;
            burst_d = 8'(BURST_LEN);
            step_d  = 1'b1;
          end else if (ev_step) begin
            step_d = 1'b1;
          end
        end
        S_RUN: begin
          if (ev_run) state_d = S_IDLE;
          else        step_d  = 1'b1;
        end
        S_BURST: begin
          if (ev_run || burst_q == 8'd1) begin
            state_d = S_IDLE;
            burst_d = '0;
          end else begin
            burst_d = burst_q - 8'd1;
            step_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      burst_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      burst_q <= burst_d;
      cyc_q   <= cyc_q + CNT_W'(step_q);
    end
  end

  assign step_en     = step_q;
  assign running     = (state_q != S_IDLE);
  assign state       = state_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller: vector table, hand sequences, random stimulus vs model.
module tb_step_controller;
  localparam int D  = 4;
  localparam int BL = 16;
  localparam int CW = 24;
`ifdef STEP_CTRL_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic          CLOCK_50  = 1'b0;
  logic          RESET     = 1'b1;
  logic          KEY_STEP  = 1'b1;
  logic          KEY_RUN   = 1'b1;
  logic          KEY_BURST = 1'b1;
  logic          halt_in   = 1'b0;
  logic          step_en, running;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;
  logic          w_step_en, w_running;
  logic [1:0]    w_state;
  logic [2:0]    w_count;

  step_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(CW), .BURST_LEN(BL)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_STEP(KEY_STEP), .KEY_RUN(KEY_RUN),
    .KEY_BURST(KEY_BURST), .halt_in(halt_in), .step_en(step_en), .running(running),
    .state(state), .cycle_count(cycle_count)
  );

  // Narrow counter instance sharing all inputs, so counter wrap is exercised often.
  step_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .BURST_LEN(BL)) dut_w (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_STEP(KEY_STEP), .KEY_RUN(KEY_RUN),
    .KEY_BURST(KEY_BURST), .halt_in(halt_in), .step_en(w_step_en), .running(w_running),
    .state(w_state), .cycle_count(w_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: keys are 0=run, 1=step, 2=burst; mode 0 idle, 1 run, 2 burst.
  logic          m_en;
  int            m_mode;
  int            m_left;
  logic [CW-1:0] m_count;
  bit            m_armed[3];
  bit            m_acc[3];
  int            m_streak[3];
  bit            m_ev[3];
  bit            m_hist[3][$];

  task automatic model_reset();
    m_en = 1'b0; m_mode = 0; m_left = 0; m_count = '0;
    for (int k = 0; k < 3; k++) begin
      m_armed[k] = 1'b0; m_acc[k] = 1'b1; m_streak[k] = 0; m_ev[k] = 1'b0;
      m_hist[k].delete();
    end
  endtask

  task automatic model_edge();
    bit raw[3];
    bit pr[3];
    bit s;
    logic nxt;
    raw = '{KEY_RUN, KEY_STEP, KEY_BURST};
    pr  = m_ev;
    m_count = m_count + CW'(m_en);
    nxt = 1'b0;
    if (halt_in) begin
      m_mode = 0; m_left = 0;
    end else begin
      case (m_mode)
        0: begin
          if (pr[0]) begin m_mode = 1; nxt = 1'b1; end
          else if (BURST_ON && pr[2]) begin m_mode = 2; m_left = BL - 1; nxt = 1'b1; end
          else if (pr[1]) nxt = 1'b1;
        end
        1: begin
          if (pr[0]) m_mode = 0;
          else nxt = 1'b1;
        end
        default: begin
          if (pr[0]) begin m_mode = 0; m_left = 0; end
          else if (m_left > 0) begin m_left--; nxt = 1'b1; end
          else m_mode = 0;
        end
      endcase
    end
    m_en = nxt;
    for (int k = 0; k < 3; k++) begin
      m_ev[k] = 1'b0;
      m_hist[k].push_back(raw[k]);
      if (m_hist[k].size() > 3) void'(m_hist[k].pop_front());
      if (m_hist[k].size() == 3) begin
        s = m_hist[k][0];
        if (!m_armed[k]) begin
          m_streak[k] = s ? m_streak[k] + 1 : 0;
          if (m_streak[k] == D) begin m_armed[k] = 1'b1; m_streak[k] = 0; end
        end else begin
          m_streak[k] = (s != m_acc[k]) ? m_streak[k] + 1 : 0;
          if (m_streak[k] == D) begin m_acc[k] = s; m_streak[k] = 0; m_ev[k] = !s; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    if (RESET) model_reset();
    else model_edge();
    @(negedge CLOCK_50);
    if (!RESET) begin
      chk("model_step_en", 32'(step_en), 32'(m_en));
      chk("model_state", 32'(state), 32'(m_mode));
      chk("model_running", 32'(running), 32'(m_mode != 0));
      chk("model_count", 32'(cycle_count), 32'(m_count));
      chk("model_w_step_en", 32'(w_step_en), 32'(m_en));
      chk("model_w_state", 32'(w_state), 32'(m_mode));
      chk("model_w_running", 32'(w_running), 32'(m_mode != 0));
      chk("model_w_count", 32'(w_count), 32'(m_count[2:0]));
    end
  endtask

  typedef struct {
    bit kstep;
    bit krun;
    bit kburst;
    bit halt;
    int exp_pulses;
    int exp_state;
  } vec_t;

  function automatic vec_t mk(bit s, bit r, bit b, bit h, int p, int st);
    vec_t v;
    v.kstep = s; v.krun = r; v.kburst = b; v.halt = h; v.exp_pulses = p; v.exp_state = st;
    return v;
  endfunction

  initial begin
    vec_t          tbl[12];
    int            pulses;
    int            first;
    int            stepcnt;
    int            rc;
    bit            halted;
    bit            ran;
    bit            saw2;
    logic [CW-1:0] base;

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 24, 1);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 30, 1);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 6, 0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 24, 1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6, 0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, BURST_ON ? 16 : 0, 0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 24, 1);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6, 0);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, BURST_ON ? 16 : 1, 0);

    model_reset();
    repeat (3) tick();
    RESET = 1'b0;

    // Idle after reset
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (step_en) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 0);
    chk("idle_state", 32'(state), 0);
    chk("idle_count", 32'(cycle_count), 0);

    // Vector table: keys low for 10 cycles, 30-cycle window
    for (int i = 0; i < 12; i++) begin
      pulses   = 0;
      halt_in  = tbl[i].halt;
      KEY_STEP = !tbl[i].kstep;
      KEY_RUN  = !tbl[i].krun;
      KEY_BURST = !tbl[i].kburst;
      for (int c = 0; c < 30; c++) begin
        tick();
        if (step_en) pulses++;
        if (c == 9) begin KEY_STEP = 1'b1; KEY_RUN = 1'b1; KEY_BURST = 1'b1; end
      end
      halt_in = 1'b0;
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
    end

    // Glitchy step press
    pulses = 0; first = -1; base = cycle_count;
    for (int c = 0; c < 40; c++) begin
      KEY_STEP = (c == 1 || c == 2 || c >= 20);
      tick();
      if (step_en) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    chk("glitch_pulses", 32'(pulses), 1);
    chk("glitch_latency", 32'(first), 9);
    chk("glitch_count", 32'(cycle_count - base), 1);

    // Run for 50 steps, then halt
    base = cycle_count; stepcnt = 0; halted = 1'b0;
    KEY_RUN = 1'b0;
    for (int c = 0; c < 80 && !halted; c++) begin
      tick();
      if (c == 9) KEY_RUN = 1'b1;
      if (step_en) stepcnt++;
      if (stepcnt == 50) begin halt_in = 1'b1; halted = 1'b1; end
    end
    KEY_RUN = 1'b1;
    chk("run_reached_50", 32'(halted), 1);
    tick();
    chk("halt_step_en", 32'(step_en), 0);
    chk("halt_state", 32'(state), 0);
    chk("halt_count", 32'(cycle_count - base), 50);
    pulses = 0;
    KEY_STEP = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (c == 9) KEY_STEP = 1'b1;
      if (step_en) pulses++;
    end
    halt_in = 1'b0;
    chk("halt_step_refused", 32'(pulses), 0);

`ifdef STEP_CTRL_BURST_EN
    // Burst aborted by a run press at the 5th step
    base = cycle_count; pulses = 0; ran = 1'b0; rc = 0;
    KEY_BURST = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c == 7) KEY_BURST = 1'b1;
      if (step_en) pulses++;
      if (pulses == 5 && !ran) begin KEY_RUN = 1'b0; ran = 1'b1; rc = c; end
      if (ran && c == rc + 10) KEY_RUN = 1'b1;
    end
    KEY_RUN = 1'b1;
    chk("abort_pulses", 32'(pulses), 11);
    chk("abort_below_16", 32'(pulses < 16), 1);
    chk("abort_state", 32'(state), 0);
    chk("abort_count", 32'(cycle_count - base), 32'(pulses));
`else
    // Burst key ignored
    pulses = 0; saw2 = 1'b0;
    KEY_BURST = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 9) KEY_BURST = 1'b1;
      if (step_en) pulses++;
      if (state == 2'd2) saw2 = 1'b1;
    end
    chk("noburst_pulses", 32'(pulses), 0);
    chk("noburst_state2", 32'(saw2), 0);
`endif

    // Async reset mid-run with a key held across reset
    KEY_RUN = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    KEY_RUN = 1'b1;
    chk("pre_reset_running", 32'(running), 1);
    KEY_STEP = 1'b0;
    repeat (5) tick();
    #2 RESET = 1'b1;
    model_reset();
    #1;
    chk("areset_step_en", 32'(step_en), 0);
    chk("areset_running", 32'(running), 0);
    chk("areset_state", 32'(state), 0);
    chk("areset_count", 32'(cycle_count), 0);
    repeat (2) tick();
    RESET = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (step_en) pulses++;
    end
    chk("held_key_no_event", 32'(pulses), 0);
    KEY_STEP = 1'b1;
    repeat (20) tick();
    pulses = 0;
    KEY_STEP = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 9) KEY_STEP = 1'b1;
      if (step_en) pulses++;
    end
    chk("repress_pulse", 32'(pulses), 1);

    // Random stimulus against the model, with one reset mid-way
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) KEY_RUN = ~KEY_RUN;
      if ($urandom_range(0, 9) == 0) KEY_STEP = ~KEY_STEP;
      if ($urandom_range(0, 9) == 0) KEY_BURST = ~KEY_BURST;
      if ($urandom_range(0, 39) == 0) halt_in = ~halt_in;
      if (c == 1500) begin
        #2 RESET = 1'b1;
        model_reset();
        tick();
        RESET = 1'b0;
      end
      tick();
    end
    KEY_RUN = 1'b1; KEY_STEP = 1'b1; KEY_BURST = 1'b1; halt_in = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
